ffsr_pulse_bank: RTL
====================

FFSR_PULSE_BANK -- requirements
Module: ffsr_pulse_bank

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 16, meaning thermometer width per channel (max value), >=2.
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of independent lanes, >=1.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load  input  1  load init into all lanes.
REQ-006 SHALL have port init  input  CHANNELS*INPUT_SIZE  per-lane initial thermometer value, lane c at slice c.
REQ-007 SHALL have port inc  input  CHANNELS  per-lane increment request.
REQ-008 SHALL have port dec  input  CHANNELS  per-lane decrement request.
REQ-009 SHALL have port fire  input  1  start temporal spike emission.
REQ-010 SHALL have port out  output  CHANNELS*INPUT_SIZE  per-lane registered thermometer value.
REQ-011 SHALL have port spike  output  CHANNELS  per-lane one-cycle spike, registered.
REQ-012 SHALL have port busy  output  1  emission window active.
REQ-013 SHALL have port done  output  1  one-cycle pulse on last window cycle.

Function
REQ-014 SHALL encode lane value v as bits 0..v-1 set, bits v..INPUT_SIZE-1 clear.
REQ-015 SHALL, on inc only, shift lane toward higher index, inserting 1 at bit 0; all-ones saturates unchanged.
REQ-016 SHALL, on dec only, shift lane toward lower index, inserting 0 at bit INPUT_SIZE-1; all-zeros saturates unchanged.
REQ-017 SHALL hold lane when inc and dec both asserted, or neither.
REQ-018 SHALL give load priority over inc/dec; loaded value appears on out the next cycle.
REQ-019 SHALL implement FSM IDLE/EMIT: IDLE->EMIT on fire; EMIT->IDLE after window; fire in EMIT ignored.
REQ-020 SHALL, on fire accepted, snapshot each lane count = popcount(out) as registered that cycle, before any same-cycle inc/dec/load.
REQ-021 SHALL run window timer t = 0..INPUT_SIZE, t=0 in the cycle after fire, busy high for all INPUT_SIZE+1 cycles.
REQ-022 SHALL assert spike[c] exactly in the cycle where t equals snapshot count of lane c (v=0 -> t=0, v=INPUT_SIZE -> t=INPUT_SIZE).
REQ-023 SHALL assert done in cycle t=INPUT_SIZE; busy low next cycle; fire in that next cycle is accepted.
REQ-024 SHALL continue applying inc/dec/load during EMIT without affecting snapshot or spike timing.
REQ-025 SHALL size counts and timer to $clog2(INPUT_SIZE+1) bits.

Reset
REQ-026 SHALL, on rst, clear out to all zeros, spike/busy/done to 0, timer to 0, FSM to IDLE, next cycle.
REQ-027 SHALL give rst priority over load, inc, dec and fire; rst mid-EMIT aborts window with no done.

Configuration
REQ-028 SHALL honour macro FFSR_INIT_CHECK_EN: when defined, a non-thermometer init lane is loaded as thermometer of its popcount and adds output init_err (1 bit, registered, high one cycle after the offending load).
REQ-029 SHALL, without FFSR_INIT_CHECK_EN, load init verbatim and omit init_err port.

Structure
REQ-030 SHALL place FSM state enum (IDLE, EMIT) and count-width helper function in shared package ffsr_pkg.
REQ-031 SHALL instantiate CHANNELS copies of sub-module ffsr_pulse_lane (register, inc/dec/load, popcount); FSM and timer in top.

Verification
REQ-032 SHALL cover: rst, then 20 inc on lane 0 -> out lane 0 = 16'hFFFF after 16, stays saturated.
REQ-033 SHALL cover: load init lanes {0,3,16,8} values, fire -> spike lanes at t=0,3,16,8; done at t=16; busy 17 cycles.
REQ-034 SHALL cover: inc and dec both high on lane 1 at value 5 -> value stays 5; dec at 0 -> stays 0.
REQ-035 SHALL cover: fire with lane 2 = 4, inc lane 2 same cycle and during window -> spike at t=4, out lane 2 = 5+ after.
REQ-036 SHALL cover: rst at t=6 of window -> busy 0, no done, no further spikes, out all zero next cycle.
REQ-037 SHALL cover (FFSR_INIT_CHECK_EN): load lane 0 init 16'b1010_0000_0000_0000 -> out = 2 ones at bits 0-1, init_err high one cycle.

Source files
------------

// File: rtl/ffsr_pkg.sv
// rtl/ffsr_pkg.sv - shared FSM state type and count-width helper for the pulse bank
package ffsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ffsr_state_t;

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ffsr_pulse_lane.sv
// rtl/ffsr_pulse_lane.sv - one thermometer lane: register, inc/dec/load, popcount
// Optional FFSR_INIT_CHECK_EN: normalises a non-thermometer init and flags it.
module ffsr_pulse_lane
    import ffsr_pkg::*;
#(
    parameter int INPUT_SIZE = 16,
    localparam int CW = count_width(INPUT_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [INPUT_SIZE-1:0] init,
    input  logic                  inc,
    input  logic                  dec,
    output logic [INPUT_SIZE-1:0] value,
`ifdef FFSR_INIT_CHECK_EN
    output logic                  init_bad,
`endif
    output logic [CW-1:0]         count
);

    function automatic logic [CW-1:0] popcount(input logic [INPUT_SIZE-1:0] d);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            cnt = cnt + CW'(d[i]);
        end
        return cnt;
    endfunction

    logic [INPUT_SIZE-1:0] load_val;

`ifdef FFSR_INIT_CHECK_EN
    function automatic logic [INPUT_SIZE-1:0] therm(input logic [CW-1:0] k);
        logic [INPUT_SIZE-1:0] t;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            t[i] = (i < int'(k));
        end
        return t;
    endfunction

    // A valid thermometer maps onto itself, so normalising every load is safe.
    assign load_val = therm(popcount(init));
    assign init_bad = load && (load_val != init);
`else
    assign load_val = init;
`endif

    // Shifting all-ones up or all-zeros down reproduces the same word, giving saturation for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc && !dec) begin
            value <= {value[INPUT_SIZE-2:0], 1'b1};
        end else if (dec && !inc) begin
            value <= {1'b0, value[INPUT_SIZE-1:1]};
        end
    end

    assign count = popcount(value);

endmodule

// File: rtl/ffsr_pulse_bank.sv
// rtl/ffsr_pulse_bank.sv - bank of thermometer lanes with temporal spike emission window
// Optional FFSR_INIT_CHECK_EN: adds init_err for non-thermometer init lanes.
module ffsr_pulse_bank
    import ffsr_pkg::*;
#(
    parameter int INPUT_SIZE = 16,
    parameter int CHANNELS   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [CHANNELS*INPUT_SIZE-1:0] init,
    input  logic [CHANNELS-1:0]            inc,
    input  logic [CHANNELS-1:0]            dec,
    input  logic                           fire,
    output logic [CHANNELS*INPUT_SIZE-1:0] out,
    output logic [CHANNELS-1:0]            spike,
    output logic                           busy,
`ifdef FFSR_INIT_CHECK_EN
    output logic                           init_err,
`endif
    output logic                           done
);

    localparam int            CW   = count_width(INPUT_SIZE);
    localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE);

    logic [CHANNELS-1:0][CW-1:0] count;
    logic [CHANNELS-1:0][CW-1:0] snap;
    logic [CHANNELS-1:0][CW-1:0] snap_n;
    logic [CW-1:0]               t;
    logic [CW-1:0]               t_n;
    logic [CHANNELS-1:0]         spike_n;
    logic                        done_n;
    logic                        accept;
    ffsr_state_t                 state;
    ffsr_state_t                 state_n;
`ifdef FFSR_INIT_CHECK_EN
    logic [CHANNELS-1:0]         bad;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        ffsr_pulse_lane #(
            .INPUT_SIZE(INPUT_SIZE)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (load),
            .init    (init[c*INPUT_SIZE +: INPUT_SIZE]),
            .inc     (inc[c]),
            .dec     (dec[c]),
            .value   (out[c*INPUT_SIZE +: INPUT_SIZE]),
`ifdef FFSR_INIT_CHECK_EN
            .init_bad(bad[c]),
`endif
            .count   (count[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (fire) state_n = EMIT;
            EMIT:    if (t == LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Spike/done are computed from the next timer value so the registered outputs line up with t.
    always_comb begin
        accept = (state == IDLE) && fire;
        snap_n = accept ? count : snap;
        if (accept) begin
            t_n = '0;
        end else if (state == EMIT && t != LAST) begin
            t_n = t + CW'(1);
        end else begin
            t_n = '0;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            spike_n[c] = (state_n == EMIT) && (snap_n[c] == t_n);
        end
        done_n = (state_n == EMIT) && (t_n == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t     <= '0;
            snap  <= '0;
            spike <= '0;
            done  <= 1'b0;
        end else begin
            t     <= t_n;
            snap  <= snap_n;
            spike <= spike_n;
            done  <= done_n;
        end
    end

    assign busy = (state == EMIT);

`ifdef FFSR_INIT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            init_err <= 1'b0;
        end else begin
            init_err <= |bad;
        end
    end
`endif

endmodule
